// File: rtl/spi_aes_master.sv
// SPI master for the AES slave: streams {plaintext,key} out on MOSI, then clocks 128 ciphertext bits in on MISO.
// Latency: start->done = 1 + CLK_DIV + 2*CLK_DIV*(256+32*Nk) + GAP_CYC + 1 clk cycles, fixed.
// Backpressure: none; start is ignored while busy, the host waits for the one-cycle done pulse.
//
// Ports:
//   clk, rst        system clock (posedge), asynchronous active-low reset
//   start           one-cycle request; pt_in/key_in are sampled in that cycle only
//   pt_in, key_in   plaintext (128 b) and key (32*Nk b), MSB shifted out first
//   busy, done      busy from the cycle after an accepted start; done pulses when ct_out updates
//   ct_out          received ciphertext, first received bit lands in bit 127; held until the next done
//   SCLK, MOSI, MISO, CS   SPI mode-0 style bus, SCLK idle low, CS active low
//   abort           only when SPI_ABORT_EN is defined: drops the frame without a done pulse
//
// Optional feature macro: SPI_ABORT_EN.
module spi_aes_master #(
   parameter int Nk      = 4,
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [127:0]      pt_in,
   input  logic [32*Nk-1:0]  key_in,
   output logic              busy,
   output logic              done,
   output logic [127:0]      ct_out,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
`ifdef SPI_ABORT_EN
   input  logic              abort,
`endif
   output logic              CS
);

   localparam int TX_W  = 128 + 32*Nk;
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int GAP_W = $clog2(GAP_CYC + 1);
   localparam int BIT_W = $clog2(TX_W + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
   localparam logic [BIT_W-1:0] TX_BITS  = BIT_W'(TX_W);
   localparam logic [BIT_W-1:0] RX_BITS  = BIT_W'(128);

   typedef enum logic [2:0] {IDLE, SETUP, SEND, GAP, RECV, DONE} state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [TX_W-1:0]   tx_sr;
   logic [127:0]      ct_sr;
   logic              abort_req;
   logic              half_end;

`ifdef SPI_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // MOSI is the top bit of the TX shift register; after the final shift the
   // register is all zeros, so MOSI is automatically low during GAP/RECV.
   assign MOSI     = tx_sr[TX_W-1];
   assign half_end = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         div_cnt <= '0;
         gap_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         ct_sr   <= '0;
         ct_out  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         SCLK    <= 1'b0;
         CS      <= 1'b1;
      end else begin
         done <= 1'b0;
         if (abort_req && state != IDLE) begin
            // Drop the frame: bus idle next cycle, ct_out untouched, no done.
            state   <= IDLE;
            div_cnt <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            busy    <= 1'b0;
            SCLK    <= 1'b0;
            CS      <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  // abort in the same idle cycle suppresses the start
                  if (start && !abort_req) begin
                     tx_sr   <= {pt_in, key_in};
                     CS      <= 1'b0;
                     busy    <= 1'b1;
                     div_cnt <= '0;
                     bit_cnt <= '0;
                     state   <= SETUP;
                  end
               end
               SETUP: begin
                  if (half_end) begin
                     div_cnt <= '0;
                     state   <= SEND;
                  end else begin
                     div_cnt <= div_cnt + DIV_W'(1);
                  end
               end
               SEND: begin
                  if (half_end) begin
                     div_cnt <= '0;
                     SCLK    <= ~SCLK;
                     if (!SCLK) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                     end else begin
                        // falling edge: present the next bit
                        tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
                        if (bit_cnt == TX_BITS) begin
                           bit_cnt <= '0;
                           gap_cnt <= '0;
                           state   <= GAP;
                        end
                     end
                  end else begin
                     div_cnt <= div_cnt + DIV_W'(1);
                  end
               end
               GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt <= '0;
                     div_cnt <= '0;
                     state   <= RECV;
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               RECV: begin
                  if (half_end) begin
                     div_cnt <= '0;
                     SCLK    <= ~SCLK;
                     if (!SCLK) begin
                        ct_sr   <= {ct_sr[126:0], MISO};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                     end else if (bit_cnt == RX_BITS) begin
                        bit_cnt <= '0;
                        state   <= DONE;
                     end
                  end else begin
                     div_cnt <= div_cnt + DIV_W'(1);
                  end
               end
               DONE: begin
                  ct_out <= ct_sr;
                  done   <= 1'b1;
                  CS     <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_aes_master.sv
// Directed bench for spi_aes_master: FIPS-197 vector through a slave model, MOSI capture, restart/reset/abort cases.
// Latency: each transfer is timed against the closed-form start->done figure.
// Backpressure: start is held high across a transfer to show it is ignored while busy.
`timescale 1ns/1ps
module tb_spi_aes_master;

   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   // u0: Nk=4, CLK_DIV=4, GAP_CYC=8.  u1: Nk=8, CLK_DIV=1, GAP_CYC=3.
   localparam int LAT0 = 1 + 4 + 2*4*(256 + 32*4) + 8 + 1;   // 3086
   localparam int LAT1 = 1 + 1 + 2*1*(256 + 32*8) + 3 + 1;   // 1030
   localparam int LIM0 = LAT0 + 50;
   localparam int LIM1 = LAT1 + 50;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- DUT 0 ----------------
   logic         rst0 = 1'b0, start0 = 1'b0, abort0 = 1'b0;
   logic [127:0] pt0 = '0, key0 = '0;
   logic         busy0, done0, sclk0, mosi0, miso0, cs0;
   logic [127:0] ct0;

   spi_aes_master #(.Nk(4), .CLK_DIV(4), .GAP_CYC(8)) u0 (
      .clk(clk), .rst(rst0), .start(start0), .pt_in(pt0), .key_in(key0),
      .busy(busy0), .done(done0), .ct_out(ct0),
      .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0),
`ifdef SPI_ABORT_EN
      .abort(abort0),
`endif
      .CS(cs0)
   );

   // Slave model: captures 256 bits, answers with the FIPS ciphertext when the
   // capture is the FIPS plaintext/key, with its complement otherwise.
   int           cnt0 = 0;
   int           rises0 = 0;
   logic [255:0] cap0 = '0;
   logic [127:0] resp0;
   assign resp0 = (cap0 == {FIPS_PT, FIPS_KEY}) ? FIPS_CT : ~FIPS_CT;
   assign miso0 = (cnt0 >= 256 && cnt0 < 384) ? resp0[383 - cnt0] : 1'b0;

   always @(negedge cs0) cnt0 = 0;
   always @(posedge sclk0) begin
      rises0++;
      if (!cs0) begin
         if (cnt0 < 256) cap0 = {cap0[254:0], mosi0};
         cnt0++;
      end
   end

   // ---------------- DUT 1 ----------------
   logic         rst1 = 1'b0, start1 = 1'b0;
   logic [127:0] pt1 = '0;
   logic [255:0] key1 = '0;
   logic         busy1, done1, sclk1, mosi1, cs1;
   logic         miso1 = 1'b1;
   logic [127:0] ct1;
`ifdef SPI_ABORT_EN
   logic         abort1 = 1'b0;
`endif

   spi_aes_master #(.Nk(8), .CLK_DIV(1), .GAP_CYC(3)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .pt_in(pt1), .key_in(key1),
      .busy(busy1), .done(done1), .ct_out(ct1),
      .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1),
`ifdef SPI_ABORT_EN
      .abort(abort1),
`endif
      .CS(cs1)
   );

   int           rises1 = 0;
   int           spacing_err1 = 0;
   int           csbad1 = 0;
   time          last_rise1 = 0;
   logic [383:0] cap1 = '0;

   always @(posedge sclk1) begin
      // rising edges are 2 clk (20 ns) apart within a burst; the gap is exempt
      if (rises1 != 0 && rises1 != 384 && ($time - last_rise1) != 20) spacing_err1++;
      last_rise1 = $time;
      if (rises1 < 384) cap1 = {cap1[382:0], mosi1};
      rises1++;
   end

   always @(posedge clk) begin
      #1;
      if (busy1 && cs1) csbad1++;
   end

   // ---------------- stimulus ----------------
   int lat;
   int n;
   int ndone;

   initial begin
      repeat (3) tick();
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_ct", ct0, 128'h0);
      check("rst_sclk", sclk0, 1'b0);
      check("rst_mosi", mosi0, 1'b0);
      check("rst_cs", cs0, 1'b1);
      rst0 = 1'b1;
      rst1 = 1'b1;
      tick();

      // Test 1: FIPS-197 vector, exact latency, inputs sampled only at start
      pt0 = FIPS_PT; key0 = FIPS_KEY; rises0 = 0;
      start0 = 1'b1; tick(); start0 = 1'b0;
      pt0 = '0; key0 = '0;
      check("t1_busy_after_start", busy0, 1'b1);
      check("t1_cs_low", cs0, 1'b0);
      lat = 1;
      while (!done0 && lat < LIM0) begin tick(); lat++; end
      check("t1_latency", lat, LAT0);
      check("t1_ct", ct0, FIPS_CT);
      check("t1_mosi_capture", cap0, {FIPS_PT, FIPS_KEY});
      check("t1_sclk_rises", rises0, 384);
      check("t1_cs_at_done", cs0, 1'b1);
      check("t1_busy_at_done", busy0, 1'b0);
      tick();
      check("t1_done_one_cycle", done0, 1'b0);
      check("t1_ct_hold", ct0, FIPS_CT);

      // Test 3: start held high throughout -> one transfer, then back-to-back restart
      pt0 = FIPS_PT; key0 = FIPS_KEY;
      start0 = 1'b1; tick();
      lat = 1; ndone = 0;
      while (!done0 && lat < LIM0) begin tick(); lat++; end
      if (done0) ndone++;
      check("t3_latency_start_held", lat, LAT0);
      check("t3_single_done", ndone, 1);
      tick(); start0 = 1'b0;
      check("t3_b2b_busy", busy0, 1'b1);
      check("t3_b2b_cs", cs0, 1'b0);

      // Test 4: reset during SEND bit 50
      n = 0;
      while (cnt0 < 50 && n < LIM0) begin tick(); n++; end
      check("t4_reached_bit50", cnt0, 50);
      rst0 = 1'b0;
      #1;
      check("t4_cs", cs0, 1'b1);
      check("t4_sclk", sclk0, 1'b0);
      check("t4_busy", busy0, 1'b0);
      check("t4_ct", ct0, 128'h0);
      tick(); rst0 = 1'b1; tick();
      start0 = 1'b1; tick(); start0 = 1'b0;
      lat = 1;
      while (!done0 && lat < LIM0) begin tick(); lat++; end
      check("t4_latency_after_rst", lat, LAT0);
      check("t4_ct_after_rst", ct0, FIPS_CT);

`ifdef SPI_ABORT_EN
      // Test 6: abort during RECV bit 10
      tick();
      start0 = 1'b1; tick(); start0 = 1'b0;
      n = 0;
      while (cnt0 < 266 && n < LIM0) begin tick(); n++; end
      abort0 = 1'b1; tick(); abort0 = 1'b0;
      check("t6_cs", cs0, 1'b1);
      check("t6_busy", busy0, 1'b0);
      check("t6_sclk", sclk0, 1'b0);
      ndone = 0;
      for (int i = 0; i < LIM0; i++) begin tick(); if (done0) ndone++; end
      check("t6_no_done", ndone, 0);
      check("t6_ct_kept", ct0, FIPS_CT);
      abort0 = 1'b1; start0 = 1'b1; tick(); abort0 = 1'b0; start0 = 1'b0;
      check("t6_abort_beats_start", busy0, 1'b0);
      start0 = 1'b1; tick(); start0 = 1'b0;
      lat = 1;
      while (!done0 && lat < LIM0) begin tick(); lat++; end
      check("t6_restart_latency", lat, LAT0);
      check("t6_restart_ct", ct0, FIPS_CT);
`endif

      // Tests 2+5: Nk=8 MOSI capture, CLK_DIV=1, MISO tied high
      pt1 = {16{8'hA5}}; key1 = {32{8'h3C}};
      rises1 = 0; spacing_err1 = 0; csbad1 = 0;
      start1 = 1'b1; tick(); start1 = 1'b0;
      lat = 1;
      while (!done1 && lat < LIM1) begin tick(); lat++; end
      check("t2_latency", lat, LAT1);
      check("t2_mosi_capture", cap1, {{16{8'hA5}}, {32{8'h3C}}});
      check("t2_sclk_rises", rises1, 512);
      check("t2_cs_low_while_busy", csbad1, 0);
      check("t2_cs_at_done", cs1, 1'b1);
      check("t5_ct_all_ones", ct1, {128{1'b1}});
      check("t5_sclk_period", spacing_err1, 0);
      tick();
      check("t2_cs_after_done", cs1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
